// File: rtl/video_fill_pkg.sv
// Shared types and constants for the rectangle-fill engine and its write arbiter.
package video_fill_pkg;
  localparam int HMAX_DEF = 640;
  localparam int VMAX_DEF = 480;

  localparam logic [1:0] REG_ORIGIN = 2'd0;
  localparam logic [1:0] REG_SIZE   = 2'd1;
  localparam logic [1:0] REG_COLOR  = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int CTRL_START   = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_CLRDONE = 2;

  typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} fill_state_e;
endpackage

// File: rtl/fill_addr_gen.sv
// Raster walker for the fill: column/row counters over the clipped rectangle,
// a row-base accumulator, and a last-pixel flag. Holds position while i_adv is low.
module fill_addr_gen #(
  parameter int HMAX = 640
) (
  input  logic        clk_sys,
  input  logic        reset_sys,
  input  logic        i_load,
  input  logic [18:0] i_row_base,
  input  logic [10:0] i_w,
  input  logic [10:0] i_h,
  input  logic        i_adv,
  output logic [18:0] o_pix_addr,
  output logic        o_last
);
  logic [10:0] r_xc, r_yc, r_w, r_h;
  logic [18:0] r_row_base;

  always_ff @(posedge clk_sys) begin
    if (reset_sys) begin
      r_xc       <= '0;
      r_yc       <= '0;
      r_w        <= '0;
      r_h        <= '0;
      r_row_base <= '0;
    end else if (i_load) begin
      r_xc       <= '0;
      r_yc       <= '0;
      r_w        <= i_w;
      r_h        <= i_h;
      r_row_base <= i_row_base;
    end else if (i_adv) begin
      if (r_xc == r_w - 11'd1) begin
        r_xc       <= '0;
        r_yc       <= r_yc + 11'd1;
        r_row_base <= r_row_base + 19'(HMAX);
      end else begin
        r_xc <= r_xc + 11'd1;
      end
    end
  end

  assign o_pix_addr = r_row_base + 19'(r_xc);
  assign o_last     = (r_xc == r_w - 11'd1) && (r_yc == r_h - 11'd1);
endmodule

// File: rtl/video_fill_arbiter.sv
// Fill register file, fill FSM and the CPU-priority write mux in front of the
// video controller. CPU cycles pass through untouched and stall the fill.
module video_fill_arbiter
  import video_fill_pkg::*;
#(
  parameter int HMAX = HMAX_DEF,
  parameter int VMAX = VMAX_DEF,
  parameter int DW   = 9
) (
  input  logic        clk_sys,
  input  logic        reset_sys,
  input  logic        cpu_video_cs,
  input  logic        cpu_video_wr,
  input  logic [20:0] cpu_video_addr,
  input  logic [31:0] cpu_video_wr_data,
  input  logic        cfg_cs,
  input  logic        cfg_wr,
  input  logic [1:0]  cfg_addr,
  input  logic [31:0] cfg_wr_data,
  output logic [31:0] cfg_rd_data,
  output logic        video_cs,
  output logic        video_wr,
  output logic [20:0] video_addr,
  output logic [31:0] video_wr_data,
  output logic        busy,
  output logic        done_irq
);
  fill_state_e   r_state;
  logic [10:0]   r_x0, r_y0, r_w, r_h;
  logic [10:0]   r_lx0, r_ly0, r_lw, r_lh;
  logic [DW-1:0] r_color, r_lcolor;
  logic          r_done, r_aborted;

  logic        w_cfg_we, w_ctrl_we, w_start, w_abort, w_clr;
  logic        w_fill_req, w_fill_go, w_last, w_empty;
  logic [10:0] w_xrem, w_yrem, w_wc, w_hc;
  logic [18:0] w_row_base, w_pix;
  logic        w_unused;

  assign w_cfg_we  = cfg_cs && cfg_wr;
  assign w_ctrl_we = w_cfg_we && (cfg_addr == REG_CTRL);
  assign w_start   = w_ctrl_we && cfg_wr_data[CTRL_START];
  assign w_abort   = w_ctrl_we && cfg_wr_data[CTRL_ABORT] && (r_state != IDLE);
  assign w_clr     = w_ctrl_we && cfg_wr_data[CTRL_CLRDONE];
  assign w_unused  = ^{cfg_wr_data[31:27], cfg_wr_data[15:11]};

  // Clipping and row base work on the copy latched at start.
  assign w_xrem     = 11'(HMAX) - r_lx0;
  assign w_yrem     = 11'(VMAX) - r_ly0;
  assign w_wc       = (r_lw < w_xrem) ? r_lw : w_xrem;
  assign w_hc       = (r_lh < w_yrem) ? r_lh : w_yrem;
  assign w_empty    = (r_lx0 >= 11'(HMAX)) || (r_ly0 >= 11'(VMAX)) ||
                      (r_lw == '0) || (r_lh == '0);
  assign w_row_base = (19'(r_ly0) << 9) + (19'(r_ly0) << 7) + 19'(r_lx0);

  // An abort or reset in the current cycle suppresses the write immediately.
  assign w_fill_req = (r_state == RUN) && !w_abort && !reset_sys;
  assign w_fill_go  = w_fill_req && !cpu_video_cs;
  assign busy       = (r_state != IDLE);
  assign done_irq   = r_done;

  fill_addr_gen #(.HMAX(HMAX)) u_addr_gen (
    .clk_sys    (clk_sys),
    .reset_sys  (reset_sys),
    .i_load     (r_state == SETUP),
    .i_row_base (w_row_base),
    .i_w        (w_wc),
    .i_h        (w_hc),
    .i_adv      (w_fill_go),
    .o_pix_addr (w_pix),
    .o_last     (w_last)
  );

  always_ff @(posedge clk_sys) begin
    if (reset_sys) begin
      r_state   <= IDLE;
      r_x0      <= '0;
      r_y0      <= '0;
      r_w       <= '0;
      r_h       <= '0;
      r_color   <= '0;
      r_lx0     <= '0;
      r_ly0     <= '0;
      r_lw      <= '0;
      r_lh      <= '0;
      r_lcolor  <= '0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      if (w_cfg_we) begin
        case (cfg_addr)
          REG_ORIGIN: begin r_x0 <= cfg_wr_data[10:0]; r_y0 <= cfg_wr_data[26:16]; end
          REG_SIZE:   begin r_w  <= cfg_wr_data[10:0]; r_h  <= cfg_wr_data[26:16]; end
          REG_COLOR:  r_color <= cfg_wr_data[DW-1:0];
          default:    ;
        endcase
      end
      if (w_clr) r_done <= 1'b0;
      // Done-set below follows the clear so a coincident set wins.
      case (r_state)
        IDLE: begin
          if (w_start && !cfg_wr_data[CTRL_ABORT]) begin
            r_state   <= SETUP;
            r_lx0     <= r_x0;
            r_ly0     <= r_y0;
            r_lw      <= r_w;
            r_lh      <= r_h;
            r_lcolor  <= r_color;
            r_aborted <= 1'b0;
          end
        end
        SETUP: begin
          if (w_abort) begin
            r_state <= IDLE; r_aborted <= 1'b1;
          end else if (w_empty) begin
            r_state <= DONE; r_done <= 1'b1;
          end else begin
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_abort) begin
            r_state <= IDLE; r_aborted <= 1'b1;
          end else if (w_fill_go && w_last) begin
            r_state <= DONE; r_done <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          if (w_abort) r_aborted <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    video_cs      = w_fill_req;
    video_wr      = w_fill_req;
    video_addr    = w_fill_req ? {2'b10, w_pix} : '0;
    video_wr_data = w_fill_req ? {{(32-DW){1'b0}}, r_lcolor} : '0;
    if (cpu_video_cs) begin
      video_cs      = 1'b1;
      video_wr      = cpu_video_wr;
      video_addr    = cpu_video_addr;
      video_wr_data = cpu_video_wr_data;
    end
  end

  always_comb begin
    cfg_rd_data = '0;
    case (cfg_addr)
      REG_ORIGIN: cfg_rd_data = {5'b0, r_y0, 5'b0, r_x0};
      REG_SIZE:   cfg_rd_data = {5'b0, r_h, 5'b0, r_w};
      REG_COLOR:  cfg_rd_data[DW-1:0] = r_color;
      default:    cfg_rd_data[2:0] = {r_aborted, r_done, busy};
    endcase
  end
endmodule

// File: tb/tb_video_fill_arbiter.sv
// Randomised self-checking bench for video_fill_arbiter against a raster-order reference model.
module tb_video_fill_arbiter;
  localparam int HMAX = 640;
  localparam int VMAX = 480;

  logic        clk_sys = 1'b0;
  logic        reset_sys = 1'b1;
  logic        cpu_video_cs = 1'b0, cpu_video_wr = 1'b0;
  logic [20:0] cpu_video_addr = '0;
  logic [31:0] cpu_video_wr_data = '0;
  logic        cfg_cs = 1'b0, cfg_wr = 1'b0;
  logic [1:0]  cfg_addr = 2'd3;
  logic [31:0] cfg_wr_data = '0;
  logic [31:0] cfg_rd_data;
  logic        video_cs, video_wr, busy, done_irq;
  logic [20:0] video_addr;
  logic [31:0] video_wr_data;

  video_fill_arbiter dut (
    .clk_sys(clk_sys), .reset_sys(reset_sys),
    .cpu_video_cs(cpu_video_cs), .cpu_video_wr(cpu_video_wr),
    .cpu_video_addr(cpu_video_addr), .cpu_video_wr_data(cpu_video_wr_data),
    .cfg_cs(cfg_cs), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wr_data(cfg_wr_data),
    .cfg_rd_data(cfg_rd_data), .video_cs(video_cs), .video_wr(video_wr),
    .video_addr(video_addr), .video_wr_data(video_wr_data),
    .busy(busy), .done_irq(done_irq)
  );

  always #5 clk_sys = ~clk_sys;

  int          cyc = 0;
  int          cpu_seen = 0, cpu_bad = 0;
  int unsigned q_addr[$];
  logic [31:0] q_data[$];
  int          q_cyc[$];
  int unsigned exp_addr[$];
  int          checks = 0, errors = 0;
  int          wr_cyc, t_start;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Capture every fill write and confirm CPU cycles pass through verbatim.
  always @(negedge clk_sys) begin
    if (cpu_video_cs) begin
      cpu_seen <= cpu_seen + 1;
      if ({video_cs, video_wr, video_addr, video_wr_data} !==
          {1'b1, cpu_video_wr, cpu_video_addr, cpu_video_wr_data})
        cpu_bad <= cpu_bad + 1;
    end else if (video_cs && video_wr) begin
      q_addr.push_back(int'(video_addr));
      q_data.push_back(video_wr_data);
      q_cyc.push_back(cyc);
    end
  end

  // Reference: raster order over the rectangle, dropping pixels outside the frame.
  task automatic build_exp(input int x0, input int y0, input int w, input int h);
    exp_addr.delete();
    for (int y = y0; y < y0 + h && y < VMAX; y++)
      for (int x = x0; x < x0 + w && x < HMAX; x++)
        exp_addr.push_back(32'h100000 + y * HMAX + x);
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk_sys); #1;
    cfg_cs = 1'b1; cfg_wr = 1'b1; cfg_addr = a; cfg_wr_data = d; wr_cyc = cyc;
    @(posedge clk_sys); #1;
    cfg_cs = 1'b0; cfg_wr = 1'b0; cfg_addr = 2'd3; cfg_wr_data = '0;
  endtask

  task automatic start_fill(input int x0, input int y0, input int w, input int h,
                            input logic [8:0] color);
    cfg_write(2'd0, {5'b0, 11'(y0), 5'b0, 11'(x0)});
    cfg_write(2'd1, {5'b0, 11'(h), 5'b0, 11'(w)});
    cfg_write(2'd2, {23'b0, color});
    cfg_write(2'd3, 32'h4);
    cfg_write(2'd3, 32'h1);
    t_start = wr_cyc;
  endtask

  // cpu_mode: 0 none, N>0 one CPU cycle every Nth cycle, <0 random 1-in-4.
  task automatic wait_done(input int budget, input int cpu_mode, output int done_cyc);
    logic c;
    done_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk_sys); #1;
      if (cpu_mode > 0) c = (i % cpu_mode) == cpu_mode - 1;
      else if (cpu_mode < 0) c = ($urandom_range(3) == 0);
      else c = 1'b0;
      cpu_video_cs = c;
      cpu_video_wr = c ? 1'($urandom_range(1)) : 1'b0;
      cpu_video_addr = 21'($urandom);
      cpu_video_wr_data = $urandom;
      @(negedge clk_sys);
      if (done_irq) begin done_cyc = cyc; break; end
    end
    #1;
    cpu_video_cs = 1'b0; cpu_video_wr = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk_sys);
    #1 reset_sys = 1'b0;
    @(negedge clk_sys);
    checks++; if ({busy, done_irq, video_cs, video_wr} !== 4'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {busy, done_irq, video_cs, video_wr}); end
    checks++; if (video_addr !== '0 || video_wr_data !== '0) begin
      errors++; $display("FAIL reset_bus: addr %h data %h want 0", video_addr, video_wr_data); end
    for (int a = 0; a < 4; a++) begin
      cfg_addr = 2'(a); #1;
      checks++; if (cfg_rd_data !== 32'h0) begin
        errors++; $display("FAIL reset_reg%0d: got %h want 0", a, cfg_rd_data); end
    end
    cfg_addr = 2'd3;
  endtask

  task automatic test_basic;
    int base, dc, n, bad;
    build_exp(10, 20, 4, 2);
    base = q_addr.size();
    start_fill(10, 20, 4, 2, 9'h1A5);
    wait_done(100, 0, dc);
    n = q_addr.size() - base; bad = 0;
    checks++; if (n !== 8) begin errors++; $display("FAIL basic_count: got %0d want 8", n); end
    for (int i = 0; i < n && i < exp_addr.size(); i++)
      if (q_addr[base+i] !== exp_addr[i] || q_data[base+i] !== 32'h1A5) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL basic_stream: %0d bad writes, want 0", bad); end
    checks++; if (n > 0 && q_cyc[base] !== t_start + 2) begin
      errors++; $display("FAIL basic_latency: first write cycle %0d want %0d", q_cyc[base], t_start + 2); end
    checks++; if (dc !== t_start + 10) begin
      errors++; $display("FAIL basic_done: done cycle %0d want %0d", dc, t_start + 10); end
    @(negedge clk_sys); #1;
    checks++; if (cfg_rd_data[2:0] !== 3'b010) begin
      errors++; $display("FAIL basic_status: got %b want 010", cfg_rd_data[2:0]); end
  endtask

  task automatic test_clip;
    int base, dc, n;
    base = q_addr.size();
    start_fill(638, 479, 8, 8, 9'h0F0);
    wait_done(100, 0, dc);
    n = q_addr.size() - base;
    checks++; if (n !== 2) begin errors++; $display("FAIL clip_count: got %0d want 2", n); end
    checks++; if (n >= 2 && (q_addr[base] !== 32'h100000 + 307198 || q_addr[base+1] !== 32'h100000 + 307199)) begin
      errors++; $display("FAIL clip_addr: got %h %h want %h %h", q_addr[base], q_addr[base+1],
                         32'h100000 + 307198, 32'h100000 + 307199); end
    checks++; if (dc !== t_start + 4) begin errors++; $display("FAIL clip_done: cycle %0d want %0d", dc, t_start + 4); end
  endtask

  task automatic test_empty;
    int base, dc;
    int xs[2] = '{5, 700};
    int ws[2] = '{0, 4};
    for (int k = 0; k < 2; k++) begin
      base = q_addr.size();
      start_fill(xs[k], 3, ws[k], 4, 9'h1FF);
      wait_done(20, 0, dc);
      checks++; if (q_addr.size() !== base) begin
        errors++; $display("FAIL empty%0d_writes: got %0d want 0", k, q_addr.size() - base); end
      checks++; if (dc !== t_start + 2) begin
        errors++; $display("FAIL empty%0d_done: cycle %0d want %0d", k, dc, t_start + 2); end
    end
  endtask

  task automatic test_cpu_interleave;
    int base, dc, n, bad, cs0, cb0;
    build_exp(100, 50, 16, 1);
    base = q_addr.size(); cs0 = cpu_seen; cb0 = cpu_bad;
    start_fill(100, 50, 16, 1, 9'h055);
    wait_done(200, 3, dc);
    @(negedge clk_sys);
    n = q_addr.size() - base; bad = 0;
    checks++; if (n !== 16) begin errors++; $display("FAIL cpu_count: got %0d want 16", n); end
    for (int i = 0; i < n && i < exp_addr.size(); i++)
      if (q_addr[base+i] !== exp_addr[i] || q_data[base+i] !== 32'h055) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL cpu_stream: %0d bad writes, want 0", bad); end
    checks++; if (cpu_bad - cb0 !== 0 || cpu_seen - cs0 < 5) begin
      errors++; $display("FAIL cpu_pass: %0d corrupted of %0d cpu cycles, want 0 of >=5",
                         cpu_bad - cb0, cpu_seen - cs0); end
  endtask

  task automatic test_abort;
    int base, n;
    base = q_addr.size();
    start_fill(0, 100, 100, 1, 9'h123);
    for (int i = 0; i < 200 && q_addr.size() - base < 5; i++) begin @(negedge clk_sys); #1; end
    cfg_write(2'd3, 32'h2);
    @(negedge clk_sys);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    repeat (10) @(negedge clk_sys);
    n = q_addr.size() - base;
    checks++; if (n !== 5) begin errors++; $display("FAIL abort_count: got %0d want 5", n); end
    checks++; if (cfg_rd_data[2:0] !== 3'b100 || done_irq !== 1'b0) begin
      errors++; $display("FAIL abort_status: got %b irq %b want 100 irq 0", cfg_rd_data[2:0], done_irq); end
  endtask

  task automatic test_busy_reset;
    int base, n, bad;
    base = q_addr.size();
    start_fill(4, 2, 50, 1, 9'h0AA);
    for (int i = 0; i < 50 && q_addr.size() - base < 2; i++) begin @(negedge clk_sys); #1; end
    cfg_write(2'd0, {5'b0, 11'd100, 5'b0, 11'd100});
    cfg_write(2'd3, 32'h1);
    @(posedge clk_sys); #1 reset_sys = 1'b1;
    @(negedge clk_sys);
    checks++; if (video_cs !== 1'b0) begin errors++; $display("FAIL reset_cycle_write: video_cs %b want 0", video_cs); end
    @(posedge clk_sys); #1 reset_sys = 1'b0;
    n = q_addr.size() - base; bad = 0;
    for (int i = 0; i < n; i++) if (q_addr[base+i] !== 32'h100000 + 2 * HMAX + 4 + i) bad++;
    checks++; if (bad !== 0 || n < 3 || n >= 50) begin
      errors++; $display("FAIL restart_ignored: %0d writes, %0d out of sequence, want 3..49 and 0", n, bad); end
    @(negedge clk_sys);
    checks++; if ({busy, done_irq, video_cs} !== 3'b0 || cfg_rd_data !== 32'h0) begin
      errors++; $display("FAIL post_reset: flags %b status %h want 000 0", {busy, done_irq, video_cs}, cfg_rd_data); end
    cfg_addr = 2'd0; #1;
    checks++; if (cfg_rd_data !== 32'h0) begin errors++; $display("FAIL post_reset_origin: got %h want 0", cfg_rd_data); end
    cfg_addr = 2'd3;
    repeat (10) @(negedge clk_sys);
    checks++; if (q_addr.size() - base !== n) begin
      errors++; $display("FAIL post_reset_quiet: %0d extra writes want 0", q_addr.size() - base - n); end
  endtask

  task automatic test_random;
    int base, dc, n, bad, cb0, x0, y0, w, h;
    logic [8:0] col;
    for (int t = 0; t < 8; t++) begin
      x0 = $urandom_range(700); y0 = $urandom_range(520);
      w = $urandom_range(30); h = $urandom_range(12); col = 9'($urandom);
      if (t < 4) begin x0 = $urandom_range(639, 600); y0 = $urandom_range(479, 460); end
      build_exp(x0, y0, w, h);
      base = q_addr.size(); cb0 = cpu_bad;
      start_fill(x0, y0, w, h, col);
      wait_done(2000, -1, dc);
      @(negedge clk_sys);
      n = q_addr.size() - base; bad = 0;
      checks++; if (dc < 0 || n !== exp_addr.size()) begin
        errors++; $display("FAIL rand%0d_count: got %0d writes (done cyc %0d) want %0d", t, n, dc, exp_addr.size()); end
      for (int i = 0; i < n && i < exp_addr.size(); i++)
        if (q_addr[base+i] !== exp_addr[i] || q_data[base+i] !== {23'b0, col}) bad++;
      checks++; if (bad !== 0 || cpu_bad !== cb0) begin
        errors++; $display("FAIL rand%0d_stream: %0d bad writes %0d bad cpu, want 0 0", t, bad, cpu_bad - cb0); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clip();
    test_empty();
    test_cpu_interleave();
    test_abort();
    test_busy_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
